// File: rtl/xadc_channel_arbiter.sv
// Round-robin merge of the voltage and current XADC sample streams into one
// tagged, framed AXI-Stream toward the COBS encoder.
module xadc_channel_arbiter #(
    parameter int           DATA_WIDTH  = 16,
    parameter int           FRAME_LEN   = 8,
    parameter logic [3:0]   VOLTAGE_TAG = 4'h1,
    parameter logic [3:0]   CURRENT_TAG = 4'h2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,

    input  logic [DATA_WIDTH-1:0]   voltage_channel_tdata_i,
    input  logic                    voltage_channel_tvalid_i,
    output logic                    voltage_channel_tready_o,

    input  logic [DATA_WIDTH-1:0]   current_monitor_channel_tdata_i,
    input  logic                    current_monitor_channel_tvalid_i,
    output logic                    current_monitor_channel_tready_o,

    output logic [DATA_WIDTH-1:0]   merged_channel_tdata_o,
    output logic                    merged_channel_tvalid_o,
    input  logic                    merged_channel_tready_i,
    output logic                    merged_channel_tlast_o,
    output logic [DATA_WIDTH/8-1:0] merged_channel_tkeep_o,
    output logic                    merged_channel_tuser_o,
    output logic                    merged_channel_tid_o,
    output logic                    merged_channel_tdest_o,

    output logic [15:0]             frame_count,
    output logic [7:0]              beat_count_o,
    output logic                    state_o
);

    // Handshake rule on every stream: a beat moves only in a cycle where
    // tvalid and tready are both high at the rising clk edge.

    localparam logic ST_EMPTY    = 1'b0;
    localparam logic ST_FULL     = 1'b1;
    localparam logic GNT_VOLTAGE = 1'b0;
    localparam logic GNT_CURRENT = 1'b1;
    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

    logic                  state_q, state_d;
    logic                  last_gnt_q, last_gnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  tlast_q, tlast_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;

    logic out_free;
    logic grant;
    logic pick_voltage;
    logic out_hs;

    // Low nibble of each input is replaced by the channel tag.
    logic unused_low_bits;
    assign unused_low_bits = ^{voltage_channel_tdata_i[3:0], current_monitor_channel_tdata_i[3:0]};

    always_comb begin
        out_free     = (state_q == ST_EMPTY) || merged_channel_tready_i;
        // Gating with rst_n keeps both input treadys low while reset is held.
        grant        = rst_n && enable && out_free &&
                       (voltage_channel_tvalid_i || current_monitor_channel_tvalid_i);
        pick_voltage = voltage_channel_tvalid_i &&
                       (!current_monitor_channel_tvalid_i || (last_gnt_q == GNT_CURRENT));
        out_hs       = (state_q == ST_FULL) && merged_channel_tready_i;

        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        data_d      = data_q;
        tlast_d     = tlast_q;
        beat_cnt_d  = beat_cnt_q;
        frame_cnt_d = frame_cnt_q;

        if (out_hs) begin
            state_d    = ST_EMPTY;
            beat_cnt_d = tlast_q ? 8'd0 : beat_cnt_q + 8'd1;
            if (tlast_q) begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
        end

        // A new beat's frame index is the count after any drain in this cycle.
        if (grant) begin
            state_d    = ST_FULL;
            last_gnt_d = pick_voltage ? GNT_VOLTAGE : GNT_CURRENT;
            data_d     = pick_voltage ?
                         {voltage_channel_tdata_i[DATA_WIDTH-1:4], VOLTAGE_TAG} :
                         {current_monitor_channel_tdata_i[DATA_WIDTH-1:4], CURRENT_TAG};
            tlast_d    = (beat_cnt_d == LAST_IDX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            last_gnt_q  <= GNT_CURRENT;
            data_q      <= '0;
            tlast_q     <= 1'b0;
            beat_cnt_q  <= 8'd0;
            frame_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            data_q      <= data_d;
            tlast_q     <= tlast_d;
            beat_cnt_q  <= beat_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign voltage_channel_tready_o         = grant && pick_voltage;
    assign current_monitor_channel_tready_o = grant && !pick_voltage;

    assign merged_channel_tdata_o  = data_q;
    assign merged_channel_tvalid_o = (state_q == ST_FULL);
    assign merged_channel_tlast_o  = tlast_q;
    assign merged_channel_tkeep_o  = '1;
    assign merged_channel_tuser_o  = 1'b0;
    assign merged_channel_tid_o    = 1'b0;
    assign merged_channel_tdest_o  = 1'b0;

    assign frame_count  = frame_cnt_q;
    assign beat_count_o = beat_cnt_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_xadc_channel_arbiter.sv
// Bench for xadc_channel_arbiter: directed scenarios plus random traffic,
// checked every cycle against a beat-list model of the arbiter.
module tb_xadc_channel_arbiter;

    localparam int DW = 16;
    localparam int FL = 8;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic [DW-1:0] v_tdata;
    logic          v_tvalid;
    logic          v_tready;
    logic [DW-1:0] c_tdata;
    logic          c_tvalid;
    logic          c_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic [1:0]    m_tkeep;
    logic          m_tuser;
    logic          m_tid;
    logic          m_tdest;
    logic [15:0]   frame_count;
    logic [7:0]    beat_count;
    logic          state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    xadc_channel_arbiter #(
        .DATA_WIDTH (DW),
        .FRAME_LEN  (FL),
        .VOLTAGE_TAG(4'h1),
        .CURRENT_TAG(4'h2)
    ) dut (
        .clk                              (clk),
        .rst_n                            (rst_n),
        .enable                           (enable),
        .voltage_channel_tdata_i          (v_tdata),
        .voltage_channel_tvalid_i         (v_tvalid),
        .voltage_channel_tready_o         (v_tready),
        .current_monitor_channel_tdata_i  (c_tdata),
        .current_monitor_channel_tvalid_i (c_tvalid),
        .current_monitor_channel_tready_o (c_tready),
        .merged_channel_tdata_o           (m_tdata),
        .merged_channel_tvalid_o          (m_tvalid),
        .merged_channel_tready_i          (m_tready),
        .merged_channel_tlast_o           (m_tlast),
        .merged_channel_tkeep_o           (m_tkeep),
        .merged_channel_tuser_o           (m_tuser),
        .merged_channel_tid_o             (m_tid),
        .merged_channel_tdest_o           (m_tdest),
        .frame_count                      (frame_count),
        .beat_count_o                     (beat_count),
        .state_o                          (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic vv, input logic [DW-1:0] vd,
                         input logic cv, input logic [DW-1:0] cd, input logic tr);
        enable   = en;
        v_tvalid = vv;
        v_tdata  = vd;
        c_tvalid = cv;
        c_tdata  = cd;
        m_tready = tr;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    // ---------------- scoreboard / model ----------------
    // exp_q holds beats accepted but not yet delivered; output beat index and
    // frame count follow from the total number of delivered beats.
    logic [DW-1:0] exp_q[$];
    int            total_out   = 0;
    bit            last_was_v  = 1'b0;

    always @(negedge clk) begin
        bit hold, free, grant, pick_v;
        if (!rst_n) begin
            exp_q.delete();
            total_out  = 0;
            last_was_v = 1'b0;
            chk("rst_tvalid", 32'(m_tvalid), 32'd0);
            chk("rst_tdata", 32'(m_tdata), 32'd0);
            chk("rst_tlast", 32'(m_tlast), 32'd0);
            chk("rst_v_tready", 32'(v_tready), 32'd0);
            chk("rst_c_tready", 32'(c_tready), 32'd0);
            chk("rst_frame_count", 32'(frame_count), 32'd0);
        end else begin
            hold   = (exp_q.size() != 0);
            free   = !hold || m_tready;
            grant  = enable && (v_tvalid || c_tvalid) && free;
            pick_v = v_tvalid && (!c_tvalid || !last_was_v);
            chk("v_tready", 32'(v_tready), 32'(grant && pick_v));
            chk("c_tready", 32'(c_tready), 32'(grant && !pick_v));
            chk("tvalid", 32'(m_tvalid), 32'(hold));
            chk("state", 32'(state_dbg), 32'(hold));
            if (hold) begin
                chk("tdata", 32'(m_tdata), 32'(exp_q[0]));
                chk("tlast", 32'(m_tlast), 32'((total_out % FL) == FL - 1));
            end
            chk("frame_count", 32'(frame_count), 32'((total_out / FL) % 65536));
            chk("beat_count", 32'(beat_count), 32'(total_out % FL));
            chk("const_side", 32'({m_tkeep, m_tuser, m_tid, m_tdest}), 32'h18);
            if (hold && m_tready) begin
                void'(exp_q.pop_front());
                total_out++;
            end
            if (grant) begin
                exp_q.push_back(pick_v ? {v_tdata[15:4], 4'h1} : {c_tdata[15:4], 4'h2});
                last_was_v = pick_v;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] held;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single source
        drive(1'b1, 1'b1, 16'hABC0, 1'b0, 16'h0000, 1'b1);
        @(negedge clk);
        chk("single_v_tready", 32'(v_tready), 32'd1);
        step();
        v_tvalid = 1'b0;
        @(negedge clk);
        chk("single_tvalid", 32'(m_tvalid), 32'd1);
        chk("single_tdata", 32'(m_tdata), 32'hABC1);
        chk("single_c_tready", 32'(c_tready), 32'd0);
        step();

        // Contention, voltage first after reset
        apply_reset();
        drive(1'b1, 1'b1, 16'h1230, 1'b1, 16'h4560, 1'b1);
        for (int k = 0; k < 6; k++) begin
            step();
            @(negedge clk);
            chk("contention", 32'(m_tdata), (k % 2 == 0) ? 32'h1231 : 32'h4562);
        end

        // Backpressure with a beat held
        step();
        m_tready = 1'b0;
        @(negedge clk);
        held = m_tdata;
        chk("bp_held", 32'(held), 32'h1231);
        for (int k = 0; k < 5; k++) begin
            step();
            @(negedge clk);
            chk("bp_stable", 32'(m_tdata), 32'(held));
            chk("bp_treadys", 32'({v_tready, c_tready}), 32'd0);
        end
        step();
        m_tready = 1'b1;
        repeat (4) step();
        drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
        step();

        // Framing: 20 beats
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 16'(i * 16 + 5), 1'b0, '0, 1'b1);
            step();
            @(negedge clk);
            chk("frame_tlast", 32'(m_tlast), 32'(i == 7 || i == 15));
        end
        v_tvalid = 1'b0;
        step();
        @(negedge clk);
        chk("frame_count_20", 32'(frame_count), 32'd2);
        chk("beat_count_20", 32'(beat_count), 32'd4);

        // Enable low drains the held beat, counters hold
        step();
        drive(1'b1, 1'b1, 16'h7770, 1'b0, '0, 1'b1);
        step();
        step();
        enable = 1'b0;
        @(negedge clk);
        chk("en_low_v_tready", 32'(v_tready), 32'd0);
        step();
        @(negedge clk);
        chk("en_low_drained", 32'(m_tvalid), 32'd0);
        chk("en_low_beat_count", 32'(beat_count), 32'd6);
        step();
        enable = 1'b1;
        repeat (3) step();
        v_tvalid = 1'b0;
        step();
        @(negedge clk);
        chk("en_resume_beat_count", 32'(beat_count), 32'd1);
        chk("en_resume_frames", 32'(frame_count), 32'd3);
        step();

        // Reset mid-frame
        apply_reset();
        drive(1'b1, 1'b1, 16'h2220, 1'b0, '0, 1'b1);
        repeat (3) step();
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_tvalid", 32'(m_tvalid), 32'd0);
        chk("midrst_frames", 32'(frame_count), 32'd0);
        chk("midrst_v_tready", 32'(v_tready), 32'd0);
        step();
        step();
        drive(1'b1, 1'b1, 16'h5550, 1'b1, 16'h6660, 1'b1);
        rst_n = 1'b1;
        step();
        @(negedge clk);
        chk("midrst_first_voltage", 32'(m_tdata), 32'h5551);
        chk("midrst_first_tlast", 32'(m_tlast), 32'd0);
        step();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 6), 16'($urandom),
                  ($urandom_range(0, 9) < 6), 16'($urandom), ($urandom_range(0, 9) < 7));
            step();
        end
        drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xadc_channel_arbiter.md
XADC_CHANNEL_ARBITER -- requirements
Module: xadc_channel_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of tdata on all three streams.
REQ-002 Parameter FRAME_LEN, default 8: output beats per frame, legal range 1..255.
REQ-003 Parameter VOLTAGE_TAG, default 4'h1: tag written into voltage beats.
REQ-004 Parameter CURRENT_TAG, default 4'h2: tag written into current beats.
REQ-005 Port clk, input, 1: single clock for the block.
REQ-006 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 Port enable, input, 1: when high, new grants are permitted.
REQ-008 Port voltage_channel, axis_interface.Sink, DATA_WIDTH: voltage samples, 12-bit sample in tdata[15:4].
REQ-009 Port current_monitor_channel, axis_interface.Sink, DATA_WIDTH: current samples, same layout.
REQ-010 Port merged_channel, axis_interface.Source, DATA_WIDTH: tagged and framed output toward the COBS encoder.
REQ-011 Port frame_count, output, 16: number of completed output frames, wrapping.

Function
REQ-012 The block SHALL use two states. EMPTY means the output register holds nothing. FULL means the output register holds a beat with merged_channel.tvalid=1.
REQ-013 A grant SHALL occur in a cycle when enable=1, at least one input tvalid=1, and the output is EMPTY or FULL with merged_channel.tready=1.
REQ-014 Only the granted input SHALL see tready=1 in that cycle, driven combinationally; the other input SHALL see tready=0.
REQ-015 Arbitration: when exactly one input is valid, that input SHALL be granted. When both are valid, the input not granted last SHALL be granted.
REQ-016 The last-grant pointer SHALL update only on a grant.
REQ-017 A granted beat SHALL appear on merged_channel the next cycle. Latency is 1 cycle.
REQ-018 Sustained throughput SHALL be 1 beat/cycle when merged_channel.tready stays high.
REQ-019 Output tdata[15:4] SHALL equal the input tdata[15:4]. Output tdata[3:0] SHALL equal the tag of the granted channel.
REQ-020 The block SHALL count output beats in a beat counter. The counter SHALL advance only on an output handshake (tvalid and tready both high).
REQ-021 merged_channel.tlast SHALL be 1 on beat index FRAME_LEN-1 only. After that beat the counter SHALL wrap to 0.
REQ-022 FRAME_LEN=1 SHALL produce tlast on every beat.
REQ-023 frame_count SHALL increment on every handshake whose tlast=1. It SHALL wrap from 16'hFFFF to 0.
REQ-024 FULL with tready=0 SHALL hold tdata and tlast stable, and both input treadys SHALL be 0.
REQ-025 FULL with tready=1 and no grant SHALL go to EMPTY. FULL with tready=1 and a grant SHALL stay FULL with the new beat.
REQ-026 Deasserting enable SHALL block new grants but SHALL still drain a FULL register. The beat counter and frame_count SHALL be held, not cleared.
REQ-027 Input tlast, tuser, tkeep, tid and tdest SHALL be ignored.
REQ-028 The output SHALL drive tkeep='1, tuser=0, tid=0, tdest=0 constantly.

Reset
REQ-029 While rst_n=0 the block SHALL be in EMPTY with merged_channel.tvalid=0, tdata=0, tlast=0, and both input treadys=0.
REQ-030 Reset SHALL clear the beat counter and frame_count to 0.
REQ-031 Reset SHALL set the last-grant pointer to current, so that voltage wins the first contention.
REQ-032 Reset asserted mid-frame SHALL discard any held beat with no partial-frame flush. After release, the next beat SHALL be beat index 0.
REQ-033 Outputs SHALL change asynchronously on rst_n falling. Release SHALL take effect at the first clk edge where rst_n is sampled high.

Verification
REQ-034 Single source: only voltage valid with tdata=16'hABC0, tready=1 -> the next cycle shows tvalid=1, tdata=16'hABC1, and current_monitor_channel.tready stays 0.
REQ-035 Contention: both inputs valid every cycle, tready=1, voltage=16'h1230, current=16'h4560 -> output beats alternate 16'h1231, 16'h4562, 16'h1231, ..., starting with voltage.
REQ-036 Backpressure: tready=0 for 5 cycles with a beat held -> tdata stable, both input treadys=0, no beat lost or duplicated after release.
REQ-037 Framing: FRAME_LEN=8, 20 beats accepted -> tlast on beats 7 and 15, frame_count=2, beat counter=4.
REQ-038 Enable low: enable drops with FULL and tready=1 -> the held beat drains and the inputs see no grants. After enable rises, framing continues at the held counter value.
REQ-039 Reset mid-frame: rst_n pulsed low after 3 beats -> tvalid=0 immediately, frame_count=0, the first beat after release has tlast=0, and voltage wins the first contention.
